vreg_group_collect: RTL and testbench

//  Consumer end of the per-register address stream: rebuilds the vector register

---
 rtl/vreg_group_collect.sv | 149 ++++++++++++++
 tb/tb_vreg_group_collect.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_group_collect.sv
// Writeback-side collector: rebuilds vector register groups from the per-register
// beat stream, retires each group as one event and keeps the busy scoreboard.
module vreg_group_collect #(
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_GROUP  = 8,
  localparam int CW   = $clog2(MAX_GROUP) + 1,
  localparam int NREG = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_claim_en,
  input  logic [ADDR_WIDTH-1:0] i_claim_addr,
  input  logic [2:0]            i_claim_vlmul,
  input  logic                  i_in_valid,
  input  logic [ADDR_WIDTH-1:0] i_in_addr,
  input  logic                  i_in_start,
  input  logic                  i_in_end,
  input  logic                  i_err_clr,
  output logic                  o_grp_done,
  output logic [ADDR_WIDTH-1:0] o_grp_base,
  output logic [CW-1:0]         o_grp_count,
  output logic [NREG-1:0]       o_reg_busy,
  output logic                  o_collecting,
  output logic [3:0]            o_err
);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base, r_expect, r_grp_base;
  logic [CW-1:0]         r_count, r_grp_count;
  logic                  r_grp_done, r_collecting;
  logic [NREG-1:0]       r_busy;
  logic [3:0]            r_err;

  state_t                w_state_n;
  logic [ADDR_WIDTH-1:0] w_base_n, w_expect_n, w_done_base;
  logic [CW-1:0]         w_count_n, w_done_cnt;
  logic                  w_done, w_restart;
  logic [3:0]            w_err_new;
  logic [3:0]            w_claim_n;
  logic [NREG-1:0]       w_clr, w_set;

  // Beat handling; a start beat inside a group aborts it and is then replayed as in IDLE.
  always_comb begin
    w_state_n   = r_state;
    w_base_n    = r_base;
    w_count_n   = r_count;
    w_expect_n  = r_expect;
    w_done      = 1'b0;
    w_done_base = r_base;
    w_done_cnt  = r_count;
    w_restart   = 1'b0;
    w_err_new   = 4'b0000;
    if (i_in_valid) begin
      if (r_state == S_COLLECT) begin
        if (i_in_start) begin
          w_err_new[1] = 1'b1;
          w_restart    = 1'b1;
        end else if (i_in_addr != r_expect) begin
          w_err_new[0] = 1'b1;
          w_state_n    = S_IDLE;
        end else if (r_count == CW'(MAX_GROUP)) begin
          w_err_new[2] = 1'b1;
          w_state_n    = S_IDLE;
        end else begin
          w_count_n  = r_count + CW'(1);
          w_expect_n = r_expect + ADDR_WIDTH'(1);
          if (i_in_end) begin
            w_done      = 1'b1;
            w_done_base = r_base;
            w_done_cnt  = r_count + CW'(1);
            w_state_n   = S_IDLE;
          end
        end
      end else begin
        w_restart = 1'b1;
      end
      if (w_restart) begin
        if (!i_in_start) begin
          w_err_new[1] = 1'b1;
        end else if (i_in_end) begin
          w_done      = 1'b1;
          w_done_base = i_in_addr;
          w_done_cnt  = CW'(1);
          w_state_n   = S_IDLE;
        end else begin
          w_state_n  = S_COLLECT;
          w_base_n   = i_in_addr;
          w_count_n  = CW'(1);
          w_expect_n = i_in_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign w_claim_n = i_claim_vlmul[2] ? 4'd1 : (4'd1 << i_claim_vlmul[1:0]);

  // Masks are built by walking forward from the base so groups wrap past the top register.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int k = 0; k < MAX_GROUP; k++) begin
      if (w_done && (CW'(k) < w_done_cnt))
        w_clr[w_done_base + ADDR_WIDTH'(k)] = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      if (i_claim_en && (4'(k) < w_claim_n))
        w_set[i_claim_addr + ADDR_WIDTH'(k)] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_expect     <= '0;
      r_count      <= '0;
      r_grp_done   <= 1'b0;
      r_grp_base   <= '0;
      r_grp_count  <= '0;
      r_collecting <= 1'b0;
      r_busy       <= '0;
      r_err        <= '0;
    end else begin
      r_state      <= w_state_n;
      r_base       <= w_base_n;
      r_expect     <= w_expect_n;
      r_count      <= w_count_n;
      r_collecting <= (w_state_n == S_COLLECT);
      r_grp_done   <= w_done;
      if (w_done) begin
        r_grp_base  <= w_done_base;
        r_grp_count <= w_done_cnt;
      end
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_err  <= (i_err_clr ? 4'b0000 : r_err) | w_err_new
              | {|(w_clr & ~r_busy), 3'b000};
    end
  end

  assign o_grp_done   = r_grp_done;
  assign o_grp_base   = r_grp_base;
  assign o_grp_count  = r_grp_count;
  assign o_reg_busy   = r_busy;
  assign o_collecting = r_collecting;
  assign o_err        = r_err;

endmodule

// File: tb/tb_vreg_group_collect.sv
// Scoreboarded bench for vreg_group_collect: expected retirements are queued when
// the end beat is driven and compared when grp_done pulses.
module tb_vreg_group_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_claim_en;
  logic [4:0]  i_claim_addr;
  logic [2:0]  i_claim_vlmul;
  logic        i_in_valid;
  logic [4:0]  i_in_addr;
  logic        i_in_start;
  logic        i_in_end;
  logic        i_err_clr;
  logic        o_grp_done;
  logic [4:0]  o_grp_base;
  logic [3:0]  o_grp_count;
  logic [31:0] o_reg_busy;
  logic        o_collecting;
  logic [3:0]  o_err;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];

  vreg_group_collect #(.ADDR_WIDTH(5), .MAX_GROUP(8)) dut (
    .clk(clk), .rst(rst),
    .i_claim_en(i_claim_en), .i_claim_addr(i_claim_addr), .i_claim_vlmul(i_claim_vlmul),
    .i_in_valid(i_in_valid), .i_in_addr(i_in_addr), .i_in_start(i_in_start),
    .i_in_end(i_in_end), .i_err_clr(i_err_clr),
    .o_grp_done(o_grp_done), .o_grp_base(o_grp_base), .o_grp_count(o_grp_count),
    .o_reg_busy(o_reg_busy), .o_collecting(o_collecting), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Retirement monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_grp_done === 1'b1) begin
      logic [8:0] exp_v;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got base=%0d count=%0d want no retirement", o_grp_base, o_grp_count);
      end else begin
        exp_v = sb.pop_front();
        if ({o_grp_base, o_grp_count} !== exp_v) begin
          errors++;
          $display("FAIL retire got base=%0d count=%0d want base=%0d count=%0d",
                   o_grp_base, o_grp_count, exp_v[8:4], exp_v[3:0]);
        end else begin
          $display("retire base=%0d count=%0d", o_grp_base, o_grp_count);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] a, input logic s, input logic e,
                      input bit exp_done, input logic [4:0] eb, input logic [3:0] ec);
    i_in_valid = 1'b1; i_in_addr = a; i_in_start = s; i_in_end = e;
    if (exp_done) sb.push_back({eb, ec});
    tick();
    i_in_valid = 1'b0; i_in_start = 1'b0; i_in_end = 1'b0;
    checks++;
    if (o_grp_done !== exp_done) begin
      errors++;
      $display("FAIL done_pulse beat=%0d got %0b want %0b", a, o_grp_done, exp_done);
    end
  endtask

  task automatic claim(input logic [4:0] a, input logic [2:0] vl);
    i_claim_en = 1'b1; i_claim_addr = a; i_claim_vlmul = vl;
    tick();
    i_claim_en = 1'b0;
  endtask

  task automatic clr_err();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
  endtask

  task automatic chk_busy(input string name, input logic [31:0] exp_v);
    checks++;
    if (o_reg_busy !== exp_v) begin
      errors++;
      $display("FAIL %s busy got %h want %h", name, o_reg_busy, exp_v);
    end
  endtask

  task automatic chk_err(input string name, input logic [3:0] exp_v);
    checks++;
    if (o_err !== exp_v) begin
      errors++;
      $display("FAIL %s err got %b want %b", name, o_err, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_grp_done, o_grp_base, o_grp_count, o_reg_busy, o_collecting, o_err} !== '0) begin
      errors++;
      $display("FAIL reset got done=%b base=%0d cnt=%0d busy=%h col=%b err=%b want all zero",
               o_grp_done, o_grp_base, o_grp_count, o_reg_busy, o_collecting, o_err);
    end
    rst = 1'b0;
    tick();
    $display("reset done");
  endtask

  task automatic test_group4();
    claim(5'd8, 3'd2);
    chk_busy("claim8", 32'h0000_0F00);
    beat(5'd8, 1'b1, 1'b0, 0, 5'd0, 4'd0);
    checks++;
    if (o_collecting !== 1'b1) begin
      errors++;
      $display("FAIL collecting_start got %b want 1", o_collecting);
    end
    beat(5'd9, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd10, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd11, 1'b0, 1'b1, 1, 5'd8, 4'd4);
    chk_busy("retire8", 32'h0);
    chk_err("retire8", 4'b0000);
    tick();
    checks++;
    if (o_grp_base !== 5'd8 || o_grp_count !== 4'd4 || o_collecting !== 1'b0) begin
      errors++;
      $display("FAIL hold got base=%0d cnt=%0d col=%b want 8 4 0", o_grp_base, o_grp_count, o_collecting);
    end
  endtask

  task automatic test_single();
    claim(5'd5, 3'b101);
    chk_busy("claim5", 32'h0000_0020);
    beat(5'd5, 1'b1, 1'b1, 1, 5'd5, 4'd1);
    chk_busy("retire5", 32'h0);
    chk_err("retire5", 4'b0000);
  endtask

  task automatic test_gap();
    beat(5'd8, 1'b1, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd9, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd11, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    chk_err("gap", 4'b0001);
    checks++;
    if (o_collecting !== 1'b0) begin
      errors++;
      $display("FAIL gap_collecting got %b want 0", o_collecting);
    end
  endtask

  task automatic test_restart();
    clr_err();
    chk_err("clear", 4'b0000);
    claim(5'd16, 3'd0);
    beat(5'd8, 1'b1, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd9, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd16, 1'b1, 1'b1, 1, 5'd16, 4'd1);
    chk_err("restart", 4'b0010);
    chk_busy("restart", 32'h0);
    tick();
    checks++;
    if (o_collecting !== 1'b0) begin
      errors++;
      $display("FAIL restart_collecting got %b want 0", o_collecting);
    end
  endtask

  task automatic test_wrap_len();
    clr_err();
    claim(5'd30, 3'd2);
    chk_busy("claim30", 32'hC000_0003);
    beat(5'd30, 1'b1, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd31, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd0, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd1, 1'b0, 1'b1, 1, 5'd30, 4'd4);
    chk_busy("wrap", 32'h0);
    chk_err("wrap", 4'b0000);
    for (int a = 0; a <= 8; a++) begin
      beat(5'(a), (a == 0), 1'b0, 0, 5'd0, 4'd0);
      if (a == 7) begin
        checks++;
        if (o_collecting !== 1'b1 || o_err !== 4'b0000) begin
          errors++;
          $display("FAIL eight_ok got col=%b err=%b want 1 0000", o_collecting, o_err);
        end
      end
    end
    chk_err("overlength", 4'b0100);
    checks++;
    if (o_collecting !== 1'b0) begin
      errors++;
      $display("FAIL len_collecting got %b want 0", o_collecting);
    end
  endtask

  task automatic test_rst_claim();
    claim(5'd20, 3'd3);
    chk_busy("claim20", 32'h0FF0_0000);
    beat(5'd8, 1'b1, 1'b0, 0, 5'd0, 4'd0);
    beat(5'd9, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_grp_done, o_grp_base, o_grp_count, o_reg_busy, o_collecting, o_err} !== '0) begin
      errors++;
      $display("FAIL async_rst got base=%0d cnt=%0d busy=%h col=%b err=%b want all zero",
               o_grp_base, o_grp_count, o_reg_busy, o_collecting, o_err);
    end
    rst = 1'b0;
    i_claim_en = 1'b1; i_claim_addr = 5'd4; i_claim_vlmul = 3'd0;
    beat(5'd4, 1'b1, 1'b1, 1, 5'd4, 4'd1);
    i_claim_en = 1'b0;
    chk_busy("set_wins", 32'h0000_0010);
    chk_err("set_wins", 4'b1000);
    clr_err();
    beat(5'd2, 1'b1, 1'b1, 1, 5'd2, 4'd1);
    chk_err("double_free", 4'b1000);
    chk_busy("double_free", 32'h0000_0010);
    i_err_clr = 1'b1;
    beat(5'd3, 1'b0, 1'b0, 0, 5'd0, 4'd0);
    i_err_clr = 1'b0;
    chk_err("clr_same_cycle", 4'b0010);
    clr_err();
    chk_err("err_clr", 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    i_claim_en = 1'b0; i_claim_addr = '0; i_claim_vlmul = '0;
    i_in_valid = 1'b0; i_in_addr = '0; i_in_start = 1'b0; i_in_end = 1'b0;
    i_err_clr = 1'b0;
    test_reset();
    test_group4();
    test_single();
    test_gap();
    test_restart();
    test_wrap_len();
    test_rst_claim();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_retire got %0d outstanding want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
